barrett_rr_sched: RTL and testbench
===================================

Name: barrett_rr_sched

Overview:
- Round-robin scheduler that shares one combinational Kyber Barrett reducer (q = 3329; 32-bit input, 16-bit canonical residue) among NREQ requesters, e.g. NTT butterfly lanes and pointwise-multiply units.
- Arbitrates requests, registers the selected operand ahead of the reducer and registers the result behind it.
- Returns results on a single response port, tagged with the requester index, under valid/ready backpressure.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, $clog2(NREQ), requester-index width.
- Q, 3329, modulus; passed through to the reducer instance.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_data  in  NREQ*32  operands, flat; requester i occupies [32*i+31:32*i].
- req_ready  out  NREQ  one-hot grant; a transfer occurs when req_valid[i] && req_ready[i].
- rsp_valid  out  1  response valid.
- rsp_data  out  16  residue, always in 0..Q-1.
- rsp_id  out  IDW  index of the requester that issued the operand.
- rsp_ready  in  1  downstream accept.
- busy  out  1  high while any pipeline stage holds data.

Behaviour:
- Reset values:
  - All pipeline valids = 0.
  - rsp_valid = 0, rsp_data = 0, rsp_id = 0, busy = 0.
  - Round-robin pointer = 0, i.e. requester 0 has highest priority.
- Two registered stages:
  - S0 holds the operand and id; its output feeds the reducer.
  - S1 holds the reducer output and id; S1 drives rsp_*.
- Latency: a transfer in cycle t appears on rsp_valid at t+2 when there is no backpressure.
- Throughput: one reduction per cycle.
- Pipeline advance:
  - adv1 = !s1_valid || rsp_ready.
  - adv0 = !s0_valid || adv1.
  - S1 loads S0 when adv1. If S0 is empty at that point, S1 valid clears.
- Arbitration (combinational):
  - When adv0 = 1, grant the first asserted req_valid searching from the pointer upward, wrapping at NREQ-1 to 0.
  - req_ready is zero when adv0 = 0 or when no requester is valid.
  - req_ready never depends on req_valid of other lanes beyond the priority search; it is one-hot or zero.
- Pointer update: on a transfer, pointer <= granted index + 1, wrapping to 0 after NREQ-1. It is unchanged when there is no transfer or the pipeline is stalled.
- Stall: rsp_valid && !rsp_ready holds rsp_data and rsp_id stable, and S0 holds its contents. A new grant is issued only if S0 is empty.
- Single active requester: it is granted every cycle, with no bubbles.
- All requesters active: grants rotate 0,1,2,3,0,...
- Reset asserted mid-operation: in-flight data is dropped with no response, and the pointer returns to 0.
- Arithmetic: the reducer's residue is used unchanged. The scheduler adds no further correction; the residue is already < Q for any 32-bit input.
- busy = s0_valid | s1_valid.

Optional Feature:
- Macro BARRETT_SCHED_PERF_EN.
- When defined:
  - Per-requester 16-bit saturating grant counters, output on perf_grants (NREQ*16, out).
  - A 16-bit saturating stall counter, output on perf_stalls (out), incremented each cycle rsp_valid && !rsp_ready.
  - All counters clear on rst.
- When undefined: these ports and registers do not exist, and the block's behaviour is otherwise identical.

Decomposition:
- Shared package barrett_pkg:
  - KYBER_Q = 3329.
  - BARRETT_MU = 32'h13AFB7.
  - Operand width 32 and residue width 16 constants.
  - A typedef for the {valid, id, data} stage record.
- Natural sub-module: rr_arbiter_nreq, the NREQ-way round-robin grant/pointer logic with an enable input.
- The reducer is instantiated once as the existing combinational barrett module.

Test Plan:
- After reset, only requester 0 sends c = 3329, then 3330, then 0 with rsp_ready = 1 → rsp_data 0, 1, 0 at t+2, t+3, t+4; rsp_id = 0.
- Requester 2 sends c = 32'hFFFFFFFF → rsp_data = 1352, rsp_id = 2, rsp_valid exactly 2 cycles after the transfer.
- All 4 requesters hold valid continuously with distinct operands → grants 0,1,2,3,0,1; responses arrive in the same order with matching ids; no cycle without a response after the first two.
- rsp_ready = 0 for 5 cycles while all requesters are valid:
  - rsp_valid and rsp_data stay stable.
  - At most 2 operands are accepted during the stall, then req_ready = 0.
  - Order is preserved when rsp_ready returns, and nothing is lost or duplicated.
- rst asserted for 1 cycle with both stages full → next cycle rsp_valid = 0, busy = 0, req_ready grants requester 0 first.
- With BARRETT_SCHED_PERF_EN: 10 grants to requester 1 and 3 stall cycles → perf_grants[1] = 10, perf_stalls = 3; both read 0 after reset.

Source files
------------

// File: rtl/barrett_pkg.sv
// Shared constants and stage records for the Kyber Barrett reduction scheduler.
package barrett_pkg;

    localparam int unsigned KYBER_Q    = 3329;
    // floor(2^32 / 3329)
    localparam logic [31:0] BARRETT_MU = 32'h0013_AFB7;

    localparam int OPW     = 32;  // operand width
    localparam int RESW    = 16;  // residue width
    localparam int ID_MAXW = 3;   // wide enough for up to 8 requesters

    // Operand stage: feeds the reducer.
    typedef struct packed {
        logic               valid;
        logic [ID_MAXW-1:0] id;
        logic [OPW-1:0]     data;
    } op_stage_t;

    // Result stage: drives the response port.
    typedef struct packed {
        logic               valid;
        logic [ID_MAXW-1:0] id;
        logic [RESW-1:0]    data;
    } rsp_stage_t;

endpackage

// File: rtl/barrett.sv
// Combinational Barrett reducer: 32-bit input to canonical residue in 0..Q-1.
module barrett
    import barrett_pkg::*;
#(
    parameter int unsigned Q = KYBER_Q
) (
    input  logic [OPW-1:0]  c,
    output logic [RESW-1:0] r
);

    localparam logic [63:0] MU = (Q == KYBER_Q) ? 64'(BARRETT_MU) : ((64'd1 << 32) / 64'(Q));
    localparam logic [31:0] QW = 32'(Q);

    logic [31:0] qe;
    logic [31:0] t;

    // Estimate the quotient, subtract, then fold the at-most-two-q excess.
    always_comb begin
        qe = 32'((64'(c) * MU) >> 32);
        t  = c - qe * QW;
        if (t >= QW) t = t - QW;
        if (t >= QW) t = t - QW;
        r  = RESW'(t);
    end

endmodule

// File: rtl/rr_arbiter_nreq.sv
// NREQ-way round-robin arbiter: combinational grant, registered priority pointer.
module rr_arbiter_nreq #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_id
);

    localparam logic [IDW:0]   N_W  = (IDW+1)'(NREQ);
    localparam logic [IDW-1:0] LAST = IDW'(NREQ - 1);

    logic [IDW-1:0] ptr;
    logic [IDW-1:0] sel;
    logic [IDW:0]   cand;
    logic           found;

    // Search from the pointer upward, wrapping, for the first active request.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        cand  = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr} + (IDW+1)'(k);
            if (cand >= N_W) cand = cand - N_W;
            if (!found && req[cand[IDW-1:0]]) begin
                found = 1'b1;
                sel   = cand[IDW-1:0];
            end
        end
    end

    // One-hot grant, suppressed while the consumer cannot accept.
    always_comb begin
        grant = '0;
        if (en && found) grant[sel] = 1'b1;
        grant_id = sel;
    end

    // After a grant, the next requester up gets top priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (en && found) begin
            ptr <= (sel == LAST) ? '0 : sel + IDW'(1);
        end
    end

endmodule

// File: rtl/barrett_rr_sched.sv
// Round-robin scheduler sharing one Barrett reducer among NREQ requesters.
// Optional counters: define BARRETT_SCHED_PERF_EN for perf_grants/perf_stalls.
//
// Handshake: every port transfers on a cycle where valid && ready are both
// high at the clock edge. req_ready is one-hot or zero and is only asserted
// when the operand stage can load; rsp_valid/rsp_id/rsp_data hold stable
// while rsp_valid && !rsp_ready.
module barrett_rr_sched
    import barrett_pkg::*;
#(
    parameter int          NREQ = 4,
    parameter int          IDW  = $clog2(NREQ),
    parameter int unsigned Q    = KYBER_Q
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*32-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic              rsp_valid,
    output logic [15:0]       rsp_data,
    output logic [IDW-1:0]    rsp_id,
    input  logic              rsp_ready,
    output logic              busy
`ifdef BARRETT_SCHED_PERF_EN
    ,
    output logic [NREQ*16-1:0] perf_grants,
    output logic [15:0]        perf_stalls
`endif
);

    op_stage_t       s0;
    rsp_stage_t      s1;
    logic            adv0;
    logic            adv1;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_id;
    logic            xfer;
    logic [OPW-1:0]  sel_data;
    logic [RESW-1:0] red_r;

    // Each stage moves when the stage behind it is empty or draining.
    always_comb begin
        adv1 = !s1.valid || rsp_ready;
        adv0 = !s0.valid || adv1;
    end

    rr_arbiter_nreq #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .clk      (clk),
        .rst      (rst),
        .en       (adv0),
        .req      (req_valid),
        .grant    (grant),
        .grant_id (grant_id)
    );

    // Grant is only raised on a valid request, so any grant bit is a transfer.
    always_comb begin
        req_ready = grant;
        xfer      = |grant;
        sel_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) sel_data = req_data[32*i +: 32];
        end
    end

    barrett #(
        .Q (Q)
    ) u_red (
        .c (s0.data),
        .r (red_r)
    );

    // Operand stage and result stage registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            s0 <= '0;
            s1 <= '0;
        end else begin
            if (adv0) begin
                s0.valid <= xfer;
                if (xfer) begin
                    s0.id   <= ID_MAXW'(grant_id);
                    s0.data <= sel_data;
                end
            end
            if (adv1) begin
                s1.valid <= s0.valid;
                if (s0.valid) begin
                    s1.id   <= s0.id;
                    s1.data <= red_r;
                end
            end
        end
    end

    // Response port is driven straight from the result stage.
    always_comb begin
        rsp_valid = s1.valid;
        rsp_data  = s1.data;
        rsp_id    = IDW'(s1.id);
        busy      = s0.valid | s1.valid;
    end

`ifdef BARRETT_SCHED_PERF_EN
    logic [15:0] grant_cnt [NREQ];
    logic [15:0] stall_cnt;

    // Saturating per-requester grant counters and response stall counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREQ; i++) grant_cnt[i] <= '0;
            stall_cnt <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (grant[i] && grant_cnt[i] != 16'hFFFF) grant_cnt[i] <= grant_cnt[i] + 16'd1;
            end
            if (s1.valid && !rsp_ready && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
        end
    end

    // Flatten the counters onto the perf port.
    always_comb begin
        perf_grants = '0;
        for (int i = 0; i < NREQ; i++) perf_grants[16*i +: 16] = grant_cnt[i];
        perf_stalls = stall_cnt;
    end
`endif

endmodule

// File: tb/tb_barrett_rr_sched.sv
// Self-checking bench for barrett_rr_sched: table vectors, corner sequences,
// random traffic, all responses checked through an expected-value queue.
module tb_barrett_rr_sched;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  // ---------------- clock / reset ----------------
  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ*32-1:0]  req_data;
  logic [NREQ-1:0]     req_ready;
  logic                rsp_valid;
  logic [15:0]         rsp_data;
  logic [IDW-1:0]      rsp_id;
  logic                rsp_ready;
  logic                busy;
`ifdef BARRETT_SCHED_PERF_EN
  logic [NREQ*16-1:0]  perf_grants;
  logic [15:0]         perf_stalls;
`endif

  always #5 clk = ~clk;

  barrett_rr_sched #(.NREQ(NREQ), .IDW(IDW), .Q(3329)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .rsp_ready (rsp_ready),
    .busy      (busy)
`ifdef BARRETT_SCHED_PERF_EN
    ,
    .perf_grants (perf_grants),
    .perf_stalls (perf_stalls)
`endif
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [IDW+15:0] exp_q[$];   // {id, residue}

  function automatic logic [15:0] ref_mod(input logic [31:0] c);
    return 16'(64'(c) % 64'd3329);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, req, $time);
  endtask

  // Push on every accepted request, pop on every accepted response.
  always @(negedge clk) begin : monitor
    logic [IDW+15:0] e;
    if (rst) begin
      exp_q.delete();
    end else begin
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_rsp", 32'(rsp_id), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("sb_rsp_id", 32'(rsp_id), 32'(e[IDW+15:16]));
          check("sb_rsp_data", 32'(rsp_data), 32'(e[15:0]));
        end
      end
      if ($countones(req_ready) > 1) check("grant_onehot", 32'(req_ready), 32'(0));
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && req_ready[i])
          exp_q.push_back({IDW'(i), ref_mod(req_data[32*i +: 32])});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic drain(input string name);
    int w;
    req_valid = '0;
    rsp_ready = 1'b1;
    w = 0;
    @(negedge clk);
    while (busy && w < 20) begin
      @(negedge clk);
      w++;
    end
    check({name, "_drained_busy"}, 32'(busy), 32'(0));
    check({name, "_drained_queue"}, 32'(exp_q.size()), 32'(0));
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    logic [IDW-1:0] id;
    logic [31:0]    c;
    logic [15:0]    r;
  } vec_t;

  vec_t vecs[10];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [31:0] vals [3];
    logic [15:0] outs [3];
    logic [15:0] held_d;
    logic [IDW-1:0] held_id;
    int accepted;
    int w;

    vecs[0] = '{id: 2'd2, c: 32'hFFFF_FFFF, r: 16'd1352};
    vecs[1] = '{id: 2'd0, c: 32'd3329,      r: 16'd0};
    vecs[2] = '{id: 2'd1, c: 32'd3328,      r: 16'd3328};
    vecs[3] = '{id: 2'd3, c: 32'd6658,      r: 16'd0};
    vecs[4] = '{id: 2'd0, c: 32'd12345,     r: 16'd2358};
    vecs[5] = '{id: 2'd1, c: 32'd100000,    r: 16'd130};
    vecs[6] = '{id: 2'd2, c: 32'd65535,     r: 16'd2284};
    vecs[7] = '{id: 2'd3, c: 32'h8000_0000, r: 16'd2341};
    vecs[8] = '{id: 2'd2, c: 32'hFFFF_FFFE, r: 16'd1351};
    vecs[9] = '{id: 2'd0, c: 32'd3330,      r: 16'd1};

    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    rsp_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    check("rst_rsp_data", 32'(rsp_data), 32'(0));
    check("rst_rsp_id", 32'(rsp_id), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_req_ready", 32'(req_ready), 32'(0));

    // Back-to-back from requester 0: 3329, 3330, 0 -> 0, 1, 0 at t+2..t+4
    vals[0] = 32'd3329; vals[1] = 32'd3330; vals[2] = 32'd0;
    outs[0] = 16'd0;    outs[1] = 16'd1;    outs[2] = 16'd0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      if (k < 3) begin
        req_valid = 4'b0001;
        req_data[31:0] = vals[k];
      end else begin
        req_valid = '0;
      end
      @(negedge clk);
      if (k < 3) check("b2b_grant", 32'(req_ready), 32'(1));
      if (k >= 2) begin
        check("b2b_rsp_valid", 32'(rsp_valid), 32'(1));
        check("b2b_rsp_data", 32'(rsp_data), 32'(outs[k-2]));
        check("b2b_rsp_id", 32'(rsp_id), 32'(0));
      end
    end
    drain("b2b");

    // Table-driven single transfers with exact latency
    for (int v = 0; v < 10; v++) begin
      tick();
      req_valid = '0;
      req_valid[vecs[v].id] = 1'b1;
      req_data[32*vecs[v].id +: 32] = vecs[v].c;
      @(negedge clk);
      w = 0;
      while (!req_ready[vecs[v].id] && w < 10) begin
        @(negedge clk);
        w++;
      end
      check("tbl_grant", 32'(req_ready[vecs[v].id]), 32'(1));
      @(posedge clk);
      #1;
      req_valid = '0;
      @(negedge clk);
      check("tbl_lat_t1_idle", 32'(rsp_valid), 32'(0));
      @(negedge clk);
      check("tbl_lat_t2_valid", 32'(rsp_valid), 32'(1));
      check("tbl_rsp_data", 32'(rsp_data), 32'(vecs[v].r));
      check("tbl_rsp_id", 32'(rsp_id), 32'(vecs[v].id));
    end
    drain("tbl");

    // All requesters active: grants rotate 0,1,2,3,... with no response bubbles
    do_reset();
    for (int i = 0; i < NREQ; i++) req_data[32*i +: 32] = $urandom();
    req_valid = '1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("rr_grant", 32'(req_ready), 32'(1) << (k % NREQ));
      if (k >= 2) check("rr_no_bubble", 32'(rsp_valid), 32'(1));
      @(posedge clk);
      #1;
    end

    // Backpressure for 5 cycles while all requesters stay valid
    rsp_ready = 1'b0;
    @(negedge clk);
    held_d  = rsp_data;
    held_id = rsp_id;
    accepted = ($countones(req_valid & req_ready) != 0) ? 1 : 0;
    for (int k = 1; k < 5; k++) begin
      @(negedge clk);
      check("stall_rsp_valid", 32'(rsp_valid), 32'(1));
      check("stall_rsp_data", 32'(rsp_data), 32'(held_d));
      check("stall_rsp_id", 32'(rsp_id), 32'(held_id));
      if ($countones(req_valid & req_ready) != 0) accepted++;
    end
    check("stall_accept_le2", 32'(accepted <= 2), 32'(1));
    check("stall_req_ready", 32'(req_ready), 32'(0));
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    repeat (6) tick();
    drain("stall");

    // Reset with both stages full
    req_valid = '1;
    rsp_ready = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("pre_rst_busy", 32'(busy), 32'(1));
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("midrst_rsp_valid", 32'(rsp_valid), 32'(0));
    check("midrst_busy", 32'(busy), 32'(0));
    check("midrst_grant0", 32'(req_ready), 32'(1));
    @(posedge clk);
    #1;
    drain("midrst");

    // Random traffic with random backpressure
    for (int k = 0; k < 400; k++) begin
      req_valid = NREQ'($urandom_range(0, (1 << NREQ) - 1));
      for (int i = 0; i < NREQ; i++) req_data[32*i +: 32] = $urandom();
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain("rand");

`ifdef BARRETT_SCHED_PERF_EN
    // Performance counters
    do_reset();
    @(negedge clk);
    check("perf_rst_grants1", 32'(perf_grants[31:16]), 32'(0));
    check("perf_rst_stalls", 32'(perf_stalls), 32'(0));
    @(posedge clk);
    #1;
    req_valid = 4'b0010;
    for (int k = 0; k < 10; k++) begin
      req_data[63:32] = $urandom();
      tick();
    end
    req_valid = '0;
    rsp_ready = 1'b0;
    repeat (3) tick();
    rsp_ready = 1'b1;
    drain("perf");
    check("perf_grants1", 32'(perf_grants[31:16]), 32'(10));
    check("perf_grants0", 32'(perf_grants[15:0]), 32'(0));
    check("perf_stalls", 32'(perf_stalls), 32'(3));
    do_reset();
    @(negedge clk);
    check("perf_clr_grants1", 32'(perf_grants[31:16]), 32'(0));
    check("perf_clr_stalls", 32'(perf_stalls), 32'(0));
`endif

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
